// File: rtl/sha_mem_responder.sv
// sha_mem_responder
// Memory-side responder for the SHA-256 engine's word-addressed bus.
// Holds the message/hash word array, gives the host a preload/readback
// port while the engine is not running, and sequences the engine's
// start/done handshake with run-time, write-count and fault reporting.

module sha_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    // engine port
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        start,
    input  logic        done,
    // host port
    input  logic        host_we,
    input  logic        host_re,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    input  logic        host_go,
    // status
    output logic        busy,
    output logic        complete,
    output logic        fault,
    output logic        err_oob,
    output logic [7:0]  wr_count,
    output logic [15:0] cycle_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_COMPLETE  = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // word storage; never reset so a preloaded message survives a reset
    logic [31:0] mem_array [DEPTH];

    logic [31:0]   mem_read_data_reg;
    logic [31:0]   host_rdata_reg;
    logic          host_rvalid_reg;
    logic          err_oob_reg;
    logic [7:0]    wr_count_reg;
    logic [15:0]   cycle_count_reg;
    logic [TW-1:0] timer_reg;

    logic          mem_in_range;
    logic          host_in_range;
    logic [AW-1:0] mem_idx;
    logic [AW-1:0] host_idx;
    logic          host_allowed;
    logic          run_active;
    logic          eng_wr;
    logic          host_wr;
    logic          host_rd;
    logic          host_oob;
    logic          launch;
    logic          timer_expired;

    assign mem_in_range  = ({1'b0, mem_addr}  < DEPTH_W);
    assign host_in_range = ({1'b0, host_addr} < DEPTH_W);
    assign mem_idx       = mem_addr[AW-1:0];
    assign host_idx      = host_addr[AW-1:0];

    // host may touch the array only while the engine is not running
    assign host_allowed  = (state_reg == ST_IDLE) || (state_reg == ST_COMPLETE) ||
                           (state_reg == ST_FAULT);
    assign run_active    = (state_reg == ST_START) || (state_reg == ST_WAIT_DONE);

    assign eng_wr        = mem_we && mem_in_range;
    assign host_wr       = host_allowed && host_we && host_in_range;
    assign host_rd       = host_allowed && host_re;
    assign host_oob      = host_allowed && (host_we || host_re) && !host_in_range;

    // a launch is any entry into START from a non-START state
    assign launch        = (state_next == ST_START) && (state_reg != ST_START);
    assign timer_expired = (timer_reg == TIMER_LAST);

    // array writes; the engine write is issued last so it wins an address clash
    always_ff @(posedge clk) begin
        if (host_wr) begin
            mem_array[host_idx] <= host_wdata;
        end
        if (eng_wr) begin
            mem_array[mem_idx] <= mem_write_data;
        end
    end

    // registered read ports with write-first bypass and the sticky range error
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_data_reg <= 32'd0;
            host_rdata_reg    <= 32'd0;
            host_rvalid_reg   <= 1'b0;
            err_oob_reg       <= 1'b0;
        end else begin
            if (!mem_in_range) begin
                mem_read_data_reg <= 32'd0;
            end else if (mem_we) begin
                mem_read_data_reg <= mem_write_data;
            end else begin
                mem_read_data_reg <= mem_array[mem_idx];
            end

            host_rvalid_reg <= host_rd;
            if (host_rd) begin
                if (!host_in_range) begin
                    host_rdata_reg <= 32'd0;
                end else if (eng_wr && (mem_idx == host_idx)) begin
                    host_rdata_reg <= mem_write_data;
                end else if (host_we) begin
                    host_rdata_reg <= host_wdata;
                end else begin
                    host_rdata_reg <= mem_array[host_idx];
                end
            end

            if (!mem_in_range || host_oob) begin
                err_oob_reg <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic: handshake progress, timeouts and launches
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (host_go) state_next = ST_START;
            end
            ST_START: begin
                if (!done)              state_next = ST_WAIT_DONE;
                else if (timer_expired) state_next = ST_FAULT;
            end
            ST_WAIT_DONE: begin
                if (done)               state_next = ST_COMPLETE;
                else if (timer_expired) state_next = ST_FAULT;
            end
            ST_COMPLETE: begin
                if (host_go) state_next = ST_START;
            end
            ST_FAULT: begin
                if (host_go) state_next = ST_START;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        start    = 1'b0;
        busy     = 1'b0;
        complete = 1'b0;
        fault    = 1'b0;
        case (state_reg)
            ST_START: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            ST_WAIT_DONE: busy     = 1'b1;
            ST_COMPLETE:  complete = 1'b1;
            ST_FAULT:     fault    = 1'b1;
            default: ;
        endcase
    end

    // run counters: cleared on launch, wait timer restarts on entering WAIT_DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg       <= '0;
            cycle_count_reg <= 16'd0;
            wr_count_reg    <= 8'd0;
        end else if (launch) begin
            timer_reg       <= '0;
            cycle_count_reg <= 16'd0;
            wr_count_reg    <= 8'd0;
        end else if (run_active) begin
            if ((state_reg == ST_START) && (state_next == ST_WAIT_DONE)) begin
                timer_reg <= '0;
            end else if (!timer_expired) begin
                timer_reg <= timer_reg + 1'b1;
            end
            if (cycle_count_reg != 16'hFFFF) begin
                cycle_count_reg <= cycle_count_reg + 16'd1;
            end
            if (eng_wr && (wr_count_reg != 8'hFF)) begin
                wr_count_reg <= wr_count_reg + 8'd1;
            end
        end
    end

    assign mem_read_data = mem_read_data_reg;
    assign host_rdata    = host_rdata_reg;
    assign host_rvalid   = host_rvalid_reg;
    assign err_oob       = err_oob_reg;
    assign wr_count      = wr_count_reg;
    assign cycle_count   = cycle_count_reg;

endmodule

// File: tb/tb_sha_mem_responder.sv
// tb_sha_mem_responder
// Directed bench for sha_mem_responder: preload, engine port latency,
// a full modelled engine run, timeout fault, host lockout and reset.

module tb_sha_mem_responder;

    logic        clk;
    logic        reset;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        start;
    logic        done;
    logic        host_we;
    logic        host_re;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        host_go;
    logic        busy;
    logic        complete;
    logic        fault;
    logic        err_oob;
    logic [7:0]  wr_count;
    logic [15:0] cycle_count;

    int n_compared;
    int n_mismatched;

    sha_mem_responder #(.DEPTH(256), .TIMEOUT(4096)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .start          (start),
        .done           (done),
        .host_we        (host_we),
        .host_re        (host_re),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_rvalid    (host_rvalid),
        .host_go        (host_go),
        .busy           (busy),
        .complete       (complete),
        .fault          (fault),
        .err_oob        (err_oob),
        .wr_count       (wr_count),
        .cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, observed);
        end
    endtask

    // advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_clear(input string tag);
        chk({tag, ".start"},       32'(start),       32'd0);
        chk({tag, ".busy"},        32'(busy),        32'd0);
        chk({tag, ".complete"},    32'(complete),    32'd0);
        chk({tag, ".fault"},       32'(fault),       32'd0);
        chk({tag, ".err_oob"},     32'(err_oob),     32'd0);
        chk({tag, ".host_rvalid"}, 32'(host_rvalid), 32'd0);
        chk({tag, ".wr_count"},    32'(wr_count),    32'd0);
        chk({tag, ".cycle_count"}, 32'(cycle_count), 32'd0);
        chk({tag, ".mem_rdata"},   mem_read_data,    32'd0);
        chk({tag, ".host_rdata"},  host_rdata,       32'd0);
    endtask

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        reset          = 1'b1;
        mem_we         = 1'b0;
        mem_addr       = 16'd0;
        mem_write_data = 32'd0;
        done           = 1'b1;
        host_we        = 1'b0;
        host_re        = 1'b0;
        host_addr      = 16'd0;
        host_wdata     = 32'd0;
        host_go        = 1'b0;

        // reset state
        repeat (3) tick();
        check_all_clear("reset");
        reset = 1'b0;
        tick();

        // preload 20 words, then read back address 7
        for (int i = 0; i < 20; i++) begin
            host_we    = 1'b1;
            host_addr  = 16'(i);
            host_wdata = 32'(i + 1);
            tick();
        end
        host_we   = 1'b0;
        host_re   = 1'b1;
        host_addr = 16'd7;
        tick();
        chk("preload.rvalid", 32'(host_rvalid), 32'd1);
        chk("preload.rdata7", host_rdata, 32'h0000_0008);
        host_re = 1'b0;
        tick();
        chk("preload.rvalid_pulse", 32'(host_rvalid), 32'd0);

        // engine read latency and write-first bypass
        mem_addr = 16'd3;
        tick();
        chk("eng.read3", mem_read_data, 32'h0000_0004);
        mem_we         = 1'b1;
        mem_write_data = 32'hDEAD_BEEF;
        tick();
        chk("eng.write_first", mem_read_data, 32'hDEAD_BEEF);
        mem_we = 1'b0;
        tick();
        chk("eng.read_back3", mem_read_data, 32'hDEAD_BEEF);
        chk("eng.no_oob", 32'(err_oob), 32'd0);

        // full run with a modelled engine
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        chk("run.start", 32'(start), 32'd1);
        chk("run.busy", 32'(busy), 32'd1);
        tick();
        // engine drops done one cycle after start and begins writing
        done           = 1'b0;
        mem_we         = 1'b1;
        mem_addr       = 16'h0080;
        mem_write_data = 32'hA000_0000;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (i == 2)   chk("run.start_dropped", 32'(start), 32'd0);
            if (i == 51)  chk("run.busy_no_rvalid", 32'(host_rvalid), 32'd0);
            if (i == 100) chk("run.busy_mid", 32'(busy), 32'd1);
            if (i < 8) begin
                mem_we         = 1'b1;
                mem_addr       = 16'(16'h0080 + i);
                mem_write_data = 32'hA000_0000 + 32'(i);
            end else begin
                mem_we = 1'b0;
            end
            // host strobes while busy must be ignored
            host_we    = (i == 50);
            host_re    = (i == 50);
            host_addr  = 16'd5;
            host_wdata = 32'h5555_5555;
            if (i == 200) done = 1'b1;
        end
        tick();
        chk("run.complete", 32'(complete), 32'd1);
        chk("run.not_busy", 32'(busy), 32'd0);
        chk("run.wr_count", 32'(wr_count), 32'd8);
        chk("run.cycle_count", 32'(cycle_count), 32'd202);
        for (int k = 0; k < 8; k++) begin
            host_re   = 1'b1;
            host_addr = 16'(16'h0080 + k);
            tick();
            chk($sformatf("run.readback%0d", k), host_rdata, 32'hA000_0000 + 32'(k));
        end
        host_addr = 16'd5;
        tick();
        chk("busy_write.addr5_unchanged", host_rdata, 32'h0000_0006);
        host_re = 1'b0;
        chk("run.no_oob", 32'(err_oob), 32'd0);

        // back to IDLE, then an out-of-range host read
        reset = 1'b1;
        tick();
        reset = 1'b0;
        host_re   = 1'b1;
        host_addr = 16'd300;
        tick();
        host_re = 1'b0;
        chk("oob.rvalid", 32'(host_rvalid), 32'd1);
        chk("oob.rdata", host_rdata, 32'd0);
        chk("oob.err_oob", 32'(err_oob), 32'd1);

        // engine never drops done: START times out after 4096 cycles
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        for (int i = 0; i < 4095; i++) tick();
        chk("timeout.still_start", 32'(start), 32'd1);
        chk("timeout.no_fault_yet", 32'(fault), 32'd0);
        tick();
        chk("timeout.fault", 32'(fault), 32'd1);
        chk("timeout.start_low", 32'(start), 32'd0);
        chk("timeout.cycle_count", 32'(cycle_count), 32'd4096);
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        chk("relaunch.start", 32'(start), 32'd1);
        chk("relaunch.cycle_count", 32'(cycle_count), 32'd0);
        chk("relaunch.wr_count", 32'(wr_count), 32'd0);

        // reset in WAIT_DONE
        done = 1'b0;
        tick();
        tick();
        chk("wait.busy", 32'(busy), 32'd1);
        chk("wait.start_low", 32'(start), 32'd0);
        reset = 1'b1;
        tick();
        check_all_clear("midrun_reset");
        reset     = 1'b0;
        done      = 1'b1;
        host_re   = 1'b1;
        host_addr = 16'd0;
        tick();
        host_re = 1'b0;
        chk("midrun_reset.array_kept", host_rdata, 32'h0000_0001);
        chk("midrun_reset.rvalid", 32'(host_rvalid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
